pool_window_feeder: RTL and testbench
=====================================

Name: pool_window_feeder

Overview:
- Upstream producer for the average-pooling stage: accepts a raster-order stream of IFM pixels, one map after another, and buffers them in a (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE shift-register line buffer.
- Emits each non-overlapping 2x2, stride-2 window as four parallel words with a one-cycle pool_enable strobe.
- Also emits the output-pixel address and map index so the downstream writer can store pooled results after the pooling stage's fixed 3-cycle latency.

Parameters:
- DATA_WIDTH, 32, pixel word width (format-agnostic; the block only moves data).
- IFM_SIZE, 14, input map width = height.
- IFM_DEPTH, 3, number of maps per frame.
- KERNAL_SIZE, 2, pooling window size; only 2 is supported (elaboration error otherwise).
- IFM_SIZE_NEXT, (IFM_SIZE-KERNAL_SIZE)/2+1, output map size.
- ADDRESS_SIZE_NEXT_IFM, $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT), output address width.
- FIFO_SIZE, (KERNAL_SIZE-1)*IFM_SIZE+KERNAL_SIZE, line-buffer depth.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  pulse; begins a frame when idle.
- data_in_valid  in  1  data_in is accepted this cycle (no backpressure).
- data_in  in  DATA_WIDTH  pixel, raster order, map-major.
- busy  out  1  high from the cycle after start until frame_done.
- pool_enable  out  1  window valid strobe (registered).
- pool_data_out_1  out  DATA_WIDTH  window top-left (r-1,c-1).
- pool_data_out_2  out  DATA_WIDTH  window top-right (r-1,c).
- pool_data_out_3  out  DATA_WIDTH  window bottom-left (r,c-1).
- pool_data_out_4  out  DATA_WIDTH  window bottom-right (r,c).
- out_addr  out  ADDRESS_SIZE_NEXT_IFM  output pixel index (r/2)*IFM_SIZE_NEXT+(c/2).
- out_map  out  $clog2(IFM_DEPTH)+1  map index of the window.
- frame_done  out  1  one-cycle pulse after the last pixel of the last map.

Behaviour:
- Reset (async): state IDLE; counters col, row, map and all shift-register entries 0; every output 0.
- FSM states:
  - IDLE: start goes to STREAM, counters cleared; data_in_valid ignored.
  - STREAM: every data_in_valid shifts data_in into sr[0] (sr[k] <= sr[k-1]), then col++. At col==IFM_SIZE-1, col wraps to 0 and row++. At row==IFM_SIZE-1 with the col wrap, row wraps to 0 and map++. Accepting the last pixel of map IFM_DEPTH-1 goes to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored.
- Window taps use the shift register after the current pixel has been shifted in: sr[0]=(r,c), sr[1]=(r,c-1), sr[IFM_SIZE]=(r-1,c), sr[IFM_SIZE+1]=(r-1,c-1).
- Window condition: the accepted pixel has row[0]==1 and col[0]==1, and both row and col are <= 2*IFM_SIZE_NEXT-1. For odd IFM_SIZE the last row and column are dropped.
- Latency: pool_enable, the four data outputs, out_addr and out_map are registered one cycle after the clock edge that accepts the completing pixel. pool_enable is high for exactly one cycle per window. The data outputs hold their values between windows.
- A new window is emitted at most every 2 accepted pixels. Gaps in data_in_valid simply stall the counters; no state is lost.
- Map boundary: the row>=1 gating ensures windows never mix pixels from two maps, so stale line-buffer contents are harmless.
- busy=1 in STREAM and DONE.
- Reset mid-frame aborts immediately: no pool_enable or frame_done follows until a new start.
- Total windows per frame = IFM_DEPTH*IFM_SIZE_NEXT^2.

Decomposition:
- Shared package: DATA_WIDTH default, FSM state encoding (IDLE/STREAM/DONE), and the IFM_SIZE_NEXT / FIFO_SIZE / address-width expressions, reused by the conv and pooling layers.
- One natural sub-module: pool_line_buffer, a parameterised FIFO_SIZE x DATA_WIDTH shift register with enable, exposing taps 0, 1, IFM_SIZE and IFM_SIZE+1.
- Counters and FSM stay in the top module.

Test Plan:
- IFM_SIZE=4, IFM_DEPTH=1, pixels 0..15 back-to-back: exactly 4 pool_enable pulses, one cycle after accepting pixels 5, 7, 13, 15. Windows (1..4) are (0,1,4,5) addr 0; (2,3,6,7) addr 1; (8,9,12,13) addr 2; (10,11,14,15) addr 3. frame_done one cycle after the last pixel.
- Same frame with data_in_valid toggling 1-0-1-0: identical windows and addresses; pool_enable spacing doubles.
- IFM_SIZE=5, depth 1, pixels 0..24: 4 windows, (0,1,5,6) (2,3,7,8) (10,11,15,16) (12,13,17,18). Row 4 and column 4 produce no pool_enable.
- IFM_SIZE=4, IFM_DEPTH=3, map m pixels = 100*m+i: 12 windows. The first window of map 1 is (100,101,104,105) with out_map=1, out_addr=0, showing no cross-map mixing.
- Reset asserted after pixel 9 of a 4x4 frame: outputs go 0 immediately. Pixels sent without start produce no pool_enable. After start, a full frame gives the correct 4 windows.
- start pulsed again mid-stream: ignored, counters unaffected, busy stays 1.

Source files
------------

// File: rtl/pool_window_feeder_pkg.sv
// Shared sizing helpers and FSM encoding for the conv/pool feeder family.
package pool_window_feeder_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic int next_size(input int ifm_size, input int kernel);
    return (ifm_size - kernel) / 2 + 1;
  endfunction

  function automatic int fifo_size(input int ifm_size, input int kernel);
    return (kernel - 1) * ifm_size + kernel;
  endfunction

  function automatic int addr_width(input int map_size);
    return (map_size * map_size > 1) ? $clog2(map_size * map_size) : 1;
  endfunction

endpackage

// File: rtl/pool_window_feeder_line_buffer.sv
// Line buffer: DEPTH x DATA_WIDTH shift register, shifts on shift_en_i, no backpressure.
// Taps are combinational views of the stored words: 0, 1, IFM_SIZE, IFM_SIZE+1.
module pool_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int IFM_SIZE   = 14,
  parameter int DEPTH      = IFM_SIZE + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] tap_0_o,
  output logic [DATA_WIDTH-1:0] tap_1_o,
  output logic [DATA_WIDTH-1:0] tap_row_o,
  output logic [DATA_WIDTH-1:0] tap_row1_o
);

  logic [DATA_WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
    end else if (shift_en_i) begin
      sr_q[0] <= data_i;
      for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  assign tap_0_o    = sr_q[0];
  assign tap_1_o    = sr_q[1];
  assign tap_row_o  = sr_q[IFM_SIZE];
  assign tap_row1_o = sr_q[IFM_SIZE+1];

endmodule

// File: rtl/pool_window_feeder.sv
// Feeds 2x2 stride-2 pooling windows from a raster pixel stream; no backpressure.
// Window outputs appear one cycle after the edge accepting the completing pixel.
module pool_window_feeder
  import pool_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH            = DATA_WIDTH_DEF,
  parameter int IFM_SIZE              = 14,
  parameter int IFM_DEPTH             = 3,
  parameter int KERNAL_SIZE           = 2,
  parameter int IFM_SIZE_NEXT         = next_size(IFM_SIZE, KERNAL_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = addr_width(IFM_SIZE_NEXT),
  parameter int FIFO_SIZE             = fifo_size(IFM_SIZE, KERNAL_SIZE)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             data_in_valid,
  input  logic [DATA_WIDTH-1:0]            data_in,
  output logic                             busy,
  output logic                             pool_enable,
  output logic [DATA_WIDTH-1:0]            pool_data_out_1,
  output logic [DATA_WIDTH-1:0]            pool_data_out_2,
  output logic [DATA_WIDTH-1:0]            pool_data_out_3,
  output logic [DATA_WIDTH-1:0]            pool_data_out_4,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] out_addr,
  output logic [$clog2(IFM_DEPTH):0]       out_map,
  output logic                             frame_done
);

  if (KERNAL_SIZE != 2) begin : g_bad_kernel
    $error("pool_window_feeder supports KERNAL_SIZE == 2 only");
  end

  localparam int CW = $clog2(IFM_SIZE);
  localparam int MW = $clog2(IFM_DEPTH) + 1;
  localparam int AW = ADDRESS_SIZE_NEXT_IFM;
  localparam logic [CW-1:0] LAST_IDX = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0] WIN_LIM  = CW'(2 * IFM_SIZE_NEXT - 1);
  localparam logic [MW-1:0] LAST_MAP = MW'(IFM_DEPTH - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [MW-1:0] map_q, map_d;
  logic          accept;
  logic          win_hit;
  logic [AW-1:0] win_addr;

  logic                  win_q;
  logic [AW-1:0]         pend_addr_q;
  logic [MW-1:0]         pend_map_q;
  logic                  pool_enable_q;
  logic [DATA_WIDTH-1:0] d1_q, d2_q, d3_q, d4_q;
  logic [AW-1:0]         addr_q;
  logic [MW-1:0]         map_out_q;
  logic [DATA_WIDTH-1:0] tap_0, tap_1, tap_row, tap_row1;

  assign accept   = (state_q == ST_STREAM) && data_in_valid;
  // Completing pixel of a window is the odd/odd one; odd-size trailing row/col never completes one.
  assign win_hit  = accept && row_q[0] && col_q[0] && (row_q <= WIN_LIM) && (col_q <= WIN_LIM);
  assign win_addr = AW'(int'(row_q >> 1) * IFM_SIZE_NEXT + int'(col_q >> 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    map_d   = map_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          col_d   = '0;
          row_d   = '0;
          map_d   = '0;
        end
      end
      ST_STREAM: begin
        if (data_in_valid) begin
          if (col_q == LAST_IDX) begin
            col_d = '0;
            if (row_q == LAST_IDX) begin
              row_d = '0;
              if (map_q == LAST_MAP) state_d = ST_DONE;
              else                   map_d   = map_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      map_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      map_q   <= map_d;
    end
  end

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IFM_SIZE   (IFM_SIZE),
    .DEPTH      (FIFO_SIZE)
  ) u_line_buffer (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (accept),
    .data_i     (data_in),
    .tap_0_o    (tap_0),
    .tap_1_o    (tap_1),
    .tap_row_o  (tap_row),
    .tap_row1_o (tap_row1)
  );

  // Stage 1 remembers the window's coordinates; stage 2 reads taps once the pixel is shifted in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_q         <= 1'b0;
      pend_addr_q   <= '0;
      pend_map_q    <= '0;
      pool_enable_q <= 1'b0;
      d1_q          <= '0;
      d2_q          <= '0;
      d3_q          <= '0;
      d4_q          <= '0;
      addr_q        <= '0;
      map_out_q     <= '0;
    end else begin
      win_q         <= win_hit;
      pool_enable_q <= win_q;
      if (win_hit) begin
        pend_addr_q <= win_addr;
        pend_map_q  <= map_q;
      end
      if (win_q) begin
        d1_q      <= tap_row1;
        d2_q      <= tap_row;
        d3_q      <= tap_1;
        d4_q      <= tap_0;
        addr_q    <= pend_addr_q;
        map_out_q <= pend_map_q;
      end
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign frame_done      = (state_q == ST_DONE);
  assign pool_enable     = pool_enable_q;
  assign pool_data_out_1 = d1_q;
  assign pool_data_out_2 = d2_q;
  assign pool_data_out_3 = d3_q;
  assign pool_data_out_4 = d4_q;
  assign out_addr        = addr_q;
  assign out_map         = map_out_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: three configurations (4x4x1, 5x5x1, 4x4x3) against a window-list model.
module tb_pool_window_feeder;

  typedef struct {
    logic [31:0] d1, d2, d3, d4;
    logic [31:0] addr;
    logic [31:0] map;
    int          k;
  } win_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start_v;
  logic        data_in_valid;
  logic [31:0] data_in;

  logic        pe_a, fd_a, busy_a, pe_b, fd_b, busy_b, pe_c, fd_c, busy_c;
  logic [31:0] a1, a2, a3, a4, b1, b2, b3, b4, c1, c2, c3, c4;
  logic [1:0]  addr_a, addr_b, addr_c;
  logic [0:0]  map_a, map_b;
  logic [2:0]  map_c;

  int          sel;
  logic        pe, fd, bsy;
  logic [31:0] d1, d2, d3, d4, addr, map;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] pix [0:74];
  logic [31:0] last_d4 [3];
  win_t        exp_q [$];

  always #5 clk = ~clk;

  pool_window_feeder #(.DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(1), .KERNAL_SIZE(2)) u_a (
    .clk(clk), .reset(reset), .start(start_v[0]), .data_in_valid(data_in_valid), .data_in(data_in),
    .busy(busy_a), .pool_enable(pe_a), .pool_data_out_1(a1), .pool_data_out_2(a2),
    .pool_data_out_3(a3), .pool_data_out_4(a4), .out_addr(addr_a), .out_map(map_a), .frame_done(fd_a));

  pool_window_feeder #(.DATA_WIDTH(32), .IFM_SIZE(5), .IFM_DEPTH(1), .KERNAL_SIZE(2)) u_b (
    .clk(clk), .reset(reset), .start(start_v[1]), .data_in_valid(data_in_valid), .data_in(data_in),
    .busy(busy_b), .pool_enable(pe_b), .pool_data_out_1(b1), .pool_data_out_2(b2),
    .pool_data_out_3(b3), .pool_data_out_4(b4), .out_addr(addr_b), .out_map(map_b), .frame_done(fd_b));

  pool_window_feeder #(.DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(3), .KERNAL_SIZE(2)) u_c (
    .clk(clk), .reset(reset), .start(start_v[2]), .data_in_valid(data_in_valid), .data_in(data_in),
    .busy(busy_c), .pool_enable(pe_c), .pool_data_out_1(c1), .pool_data_out_2(c2),
    .pool_data_out_3(c3), .pool_data_out_4(c4), .out_addr(addr_c), .out_map(map_c), .frame_done(fd_c));

  always_comb begin
    pe = pe_a; fd = fd_a; bsy = busy_a;
    d1 = a1; d2 = a2; d3 = a3; d4 = a4;
    addr = {30'd0, addr_a}; map = {31'd0, map_a};
    case (sel)
      1: begin
        pe = pe_b; fd = fd_b; bsy = busy_b;
        d1 = b1; d2 = b2; d3 = b3; d4 = b4;
        addr = {30'd0, addr_b}; map = {31'd0, map_b};
      end
      2: begin
        pe = pe_c; fd = fd_c; bsy = busy_c;
        d1 = c1; d2 = c2; d3 = c3; d4 = c4;
        addr = {30'd0, addr_c}; map = {29'd0, map_c};
      end
      default: ;
    endcase
  end

  task automatic do_reset();
    reset = 1'b1;
    start_v = '0;
    data_in_valid = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) last_d4[s] = '0;
  endtask

  // gap: 0 back-to-back, 1 alternate valid, 2 random valid; mode: 0 pattern 100*m+i, 1 random data
  task automatic run_frame(input int s, input int n, input int depth, input int mode,
                           input int gap, input int mid_start);
    int   nn, total, idx, prev_acc, cur_acc, cyc, base;
    logic ve, exp_pe, exp_busy, exp_fd;
    win_t w;
    sel   = s;
    nn    = (n - 2) / 2 + 1;
    total = depth * n * n;
    for (int i = 0; i < total; i++)
      pix[i] = (mode == 0) ? 32'(100 * (i / (n * n)) + i % (n * n)) : $urandom;
    exp_q.delete();
    for (int m = 0; m < depth; m++)
      for (int r = 0; r < nn; r++)
        for (int c = 0; c < nn; c++) begin
          base   = m * n * n;
          w.d1   = pix[base + 2*r*n + 2*c];
          w.d2   = pix[base + 2*r*n + 2*c + 1];
          w.d3   = pix[base + (2*r+1)*n + 2*c];
          w.d4   = pix[base + (2*r+1)*n + 2*c + 1];
          w.addr = 32'(r * nn + c);
          w.map  = 32'(m);
          w.k    = base + (2*r+1)*n + 2*c + 1;
          exp_q.push_back(w);
        end

    @(negedge clk);
    start_v[s] = 1'b1;
    data_in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (bsy !== 1'b1) $display("FAIL busy_after_start dut%0d got %b want 1", s, bsy);
    else pass_cnt++;
    @(negedge clk);
    start_v[s] = 1'b0;

    idx = 0; prev_acc = -1; cyc = 0;
    while ((idx < total || prev_acc >= 0) && cyc < 3000) begin
      @(negedge clk);
      ve = (idx < total) && (gap == 0 || (gap == 1 && cyc % 2 == 0) ||
                             (gap == 2 && $urandom_range(0, 2) != 0));
      start_v[s] = (mid_start != 0) && (idx == 7);
      data_in_valid = ve;
      data_in = ve ? pix[idx] : $urandom;
      @(posedge clk); #1;
      cur_acc = ve ? idx : -1;
      if (ve) idx++;
      cyc++;

      exp_pe   = (exp_q.size() > 0) && (prev_acc >= 0) && (exp_q[0].k == prev_acc);
      exp_fd   = (cur_acc == total - 1);
      exp_busy = !(idx == total && cur_acc < 0);

      total_cnt++;
      if (pe !== exp_pe) $display("FAIL pool_enable dut%0d cyc%0d got %b want %b", s, cyc, pe, exp_pe);
      else pass_cnt++;
      total_cnt++;
      if (fd !== exp_fd) $display("FAIL frame_done dut%0d cyc%0d got %b want %b", s, cyc, fd, exp_fd);
      else pass_cnt++;
      total_cnt++;
      if (bsy !== exp_busy) $display("FAIL busy dut%0d cyc%0d got %b want %b", s, cyc, bsy, exp_busy);
      else pass_cnt++;

      if (exp_pe) begin
        w = exp_q.pop_front();
        total_cnt++;
        if ({d1, d2, d3, d4} !== {w.d1, w.d2, w.d3, w.d4})
          $display("FAIL window_data dut%0d got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
                   s, d1, d2, d3, d4, w.d1, w.d2, w.d3, w.d4);
        else pass_cnt++;
        total_cnt++;
        if (addr !== w.addr) $display("FAIL out_addr dut%0d got %0d want %0d", s, addr, w.addr);
        else pass_cnt++;
        total_cnt++;
        if (map !== w.map) $display("FAIL out_map dut%0d got %0d want %0d", s, map, w.map);
        else pass_cnt++;
        last_d4[s] = w.d4;
      end else begin
        total_cnt++;
        if (d4 !== last_d4[s]) $display("FAIL data_hold dut%0d got %0d want %0d", s, d4, last_d4[s]);
        else pass_cnt++;
      end
      prev_acc = cur_acc;
    end
    start_v[s] = 1'b0;
    data_in_valid = 1'b0;

    total_cnt++;
    if (cyc >= 3000) $display("FAIL frame_timeout dut%0d got %0d cycles want < 3000", s, cyc);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL missing_windows dut%0d got %0d left want 0", s, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      total_cnt++;
      if ({pe, fd, bsy} !== 3'b000) $display("FAIL reset_ctrl dut%0d got %b want 000", s, {pe, fd, bsy});
      else pass_cnt++;
      total_cnt++;
      if ({d1, d2, d3, d4, addr, map} !== '0)
        $display("FAIL reset_data dut%0d got %0d,%0d,%0d,%0d,%0d,%0d want 0", s, d1, d2, d3, d4, addr, map);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    sel = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      data_in_valid = 1'b1;
      data_in = 32'(i);
      @(posedge clk);
      if (i != 9) @(negedge clk);
    end
    #2;
    total_cnt++;
    if (d4 !== 32'd7) $display("FAIL pre_abort_window got %0d want 7", d4);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({pe, fd, bsy} !== 3'b000) $display("FAIL abort_ctrl got %b want 000", {pe, fd, bsy});
    else pass_cnt++;
    total_cnt++;
    if ({d1, d2, d3, d4, addr} !== '0) $display("FAIL abort_data got %0d,%0d,%0d,%0d,%0d want 0", d1, d2, d3, d4, addr);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    for (int s = 0; s < 3; s++) last_d4[s] = '0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      data_in_valid = 1'b1;
      data_in = $urandom;
      @(posedge clk); #1;
      total_cnt++;
      if ({pe, fd, bsy} !== 3'b000) $display("FAIL nostart_quiet i%0d got %b want 000", i, {pe, fd, bsy});
      else pass_cnt++;
    end
    @(negedge clk);
    data_in_valid = 1'b0;
    run_frame(0, 4, 1, 1, 0, 0);
  endtask

  task automatic test_basic();
    do_reset();
    run_frame(0, 4, 1, 0, 0, 0);
  endtask

  task automatic test_valid_gaps();
    do_reset();
    run_frame(0, 4, 1, 0, 1, 0);
    run_frame(0, 4, 1, 1, 2, 0);
  endtask

  task automatic test_odd_size();
    do_reset();
    run_frame(1, 5, 1, 0, 0, 0);
    run_frame(1, 5, 1, 1, 2, 0);
  endtask

  task automatic test_multi_map();
    do_reset();
    run_frame(2, 4, 3, 0, 0, 0);
    run_frame(2, 4, 3, 1, 2, 0);
  endtask

  task automatic test_mid_start();
    do_reset();
    run_frame(0, 4, 1, 1, 0, 1);
    run_frame(2, 4, 3, 1, 2, 1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 0; f < 3; f++) run_frame(2, 4, 3, 1, f % 3, 0);
    run_frame(1, 5, 1, 1, 0, 0);
    run_frame(1, 5, 1, 0, 1, 0);
  endtask

  initial begin
    sel = 0;
    reset = 1'b1;
    start_v = '0;
    data_in_valid = 1'b0;
    data_in = '0;
    test_reset();
    test_basic();
    test_valid_gaps();
    test_odd_size();
    test_multi_map();
    test_reset_abort();
    test_mid_start();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
